// File: rtl/pll_rst_seq_pkg.sv
// pll_rst_seq_pkg: shared state encoding and loss-counter constants for pll_rst_seq.
package pll_rst_seq_pkg;
   typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} pll_rst_state_t;
   localparam int LOSS_CNT_W = 8;
   localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;
endpackage

// File: rtl/lock_sync.sv
// lock_sync: N-stage single-bit synchronizer for asynchronous inputs, cleared by synchronous rst.
module lock_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic [N-1:0] r_sync;
   always_ff @(posedge clk)
      r_sync <= rst ? '0 : {r_sync[N-2:0], i_d};
   assign o_q = r_sync[N-1];
endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: qualifies PLL lock over a stable window, then releases a synchronous reset.
// Define PLL_RST_SEQ_LOSS_CNT_EN to implement the saturating loss_cnt register (otherwise tied to 0).
module pll_rst_seq
   import pll_rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 1024,
   parameter int HOLD_CYCLES   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lock_in,
   input  logic                  rst_req,
   output logic                  rst_out,
   output logic                  ready,
   output logic                  lock_lost,
   output logic [LOSS_CNT_W-1:0] loss_cnt
);
   localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);
   pll_rst_state_t r_state;
   logic [CW-1:0]  r_cnt;
   logic           r_rst_out;
   logic           r_ready;
   logic           r_lock_lost;
   logic           w_lock_s;
   logic [CW-1:0]  w_cnt_inc;
   logic           w_loss;
   lock_sync #(.N(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .i_d (lock_in),
      .o_q (w_lock_s)
   );
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_loss    = (r_state == RUN) && !w_lock_s;
   // The transition is taken on the edge that completes the count, so each window spans exactly its cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= WAIT_LOCK;
         r_cnt       <= '0;
         r_rst_out   <= 1'b1;
         r_ready     <= 1'b0;
         r_lock_lost <= 1'b0;
      end else begin
         case (r_state)
            WAIT_LOCK: if (w_lock_s) begin
               r_state <= (STABLE_CYCLES == 1) ? HOLD : STABLE;
               r_cnt   <= (STABLE_CYCLES == 1) ? '0 : CW'(1);
            end
            STABLE: if (!w_lock_s) begin
               r_state <= WAIT_LOCK;
               r_cnt   <= '0;
            end else if (w_cnt_inc == CW'(STABLE_CYCLES)) begin
               r_state <= HOLD;
               r_cnt   <= '0;
            end else
               r_cnt <= w_cnt_inc;
            HOLD: if (!w_lock_s) begin
               r_state <= WAIT_LOCK;
               r_cnt   <= '0;
            end else if (w_cnt_inc == CW'(HOLD_CYCLES)) begin
               r_state   <= RUN;
               r_cnt     <= '0;
               r_rst_out <= 1'b0;
               r_ready   <= 1'b1;
            end else
               r_cnt <= w_cnt_inc;
            RUN: if (!w_lock_s) begin
               r_state     <= WAIT_LOCK;
               r_cnt       <= '0;
               r_rst_out   <= 1'b1;
               r_ready     <= 1'b0;
               r_lock_lost <= 1'b1;
            end else if (rst_req) begin
               r_state   <= HOLD;
               r_cnt     <= '0;
               r_rst_out <= 1'b1;
               r_ready   <= 1'b0;
            end
         endcase
      end
   end
   assign rst_out   = r_rst_out;
   assign ready     = r_ready;
   assign lock_lost = r_lock_lost;
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] r_loss_cnt;
   always_ff @(posedge clk) begin
      if (rst)
         r_loss_cnt <= '0;
      else if (w_loss && r_loss_cnt != LOSS_CNT_MAX)
         r_loss_cnt <= r_loss_cnt + 1'b1;
   end
   assign loss_cnt = r_loss_cnt;
`else
   logic w_unused_loss;
   assign w_unused_loss = w_loss;
   assign loss_cnt = '0;
`endif
endmodule
